// File: rtl/morse_msg_sequencer.sv
// Morse message sequencer: queues 3-bit letter codes (A-H) and plays each one's
// trimmed dot/dash pattern, one unit per DIV clocks, followed by a fixed gap.
module morse_msg_sequencer #(
    parameter int DIV        = 250,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_UNITS  = 3
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic [2:0] LetterIn,
    input  logic       LetterValid,
    output logic       LetterReady,
    input  logic       Abort,
    output logic       DotDashOut,
    output logic       NewBitOut,
    output logic       Busy,
    output logic       Done
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W = $clog2(GAP_UNITS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_UNITS - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    function automatic logic [10:0] pattern(input logic [2:0] code);
        case (code)
            3'd0:    return 11'b10111000000;
            3'd1:    return 11'b11101010100;
            3'd2:    return 11'b11101011101;
            3'd3:    return 11'b11101010000;
            3'd4:    return 11'b10000000000;
            3'd5:    return 11'b10101110100;
            3'd6:    return 11'b11101110100;
            default: return 11'b10101010000;
        endcase
    endfunction

    logic [2:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    state_t           state;
    logic [2:0]       cur;
    logic [10:0]      shreg;
    logic [CNT_W-1:0] cnt;
    logic [GAP_W-1:0] gapcnt;
    logic             dot_dash;

    logic        empty, full, push, pop, tick, gap_last;
    logic [10:0] cur_pattern, shifted;

    assign empty       = (count == '0);
    assign full        = (count == FULL_COUNT);
    assign tick        = (cnt == '0);
    assign gap_last    = (state == GAP) && tick && (gapcnt == '0);
    assign cur_pattern = pattern(cur);
    assign shifted     = {shreg[9:0], 1'b0};

    assign LetterReady = !full && !Abort;
    assign push        = LetterValid && LetterReady;
    // A letter leaves the queue only when the FSM is about to enter LOAD.
    assign pop         = !Abort && !empty && ((state == IDLE) || gap_last);

    assign DotDashOut  = dot_dash;
    assign NewBitOut   = ((state == SEND) || (state == GAP)) && tick && !Abort;
    assign Done        = gap_last && empty && !Abort;
    assign Busy        = (state != IDLE) || !empty;

    // NOTE: queue storage is left unreset; count gates every read, so stale entries are never seen.
    always_ff @(posedge ClockIn) begin
        if (push) mem[wr_ptr] <= LetterIn;
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (Abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cur      <= '0;
            shreg    <= '0;
            cnt      <= '0;
            gapcnt   <= '0;
            dot_dash <= 1'b0;
        end else if (Abort) begin
            state    <= IDLE;
            dot_dash <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dot_dash <= 1'b0;
                    if (!empty) begin
                        cur   <= mem[rd_ptr];
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg    <= cur_pattern;
                    cnt      <= CNT_RELOAD;
                    dot_dash <= cur_pattern[10];
                    state    <= SEND;
                end
                SEND: begin
                    if (tick) begin
                        cnt   <= CNT_RELOAD;
                        shreg <= shifted;
                        // Trailing zeros are trimmed: an all-zero remainder ends the letter.
                        if (shifted == '0) begin
                            gapcnt   <= GAP_RELOAD;
                            dot_dash <= 1'b0;
                            state    <= GAP;
                        end else begin
                            dot_dash <= shifted[10];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    dot_dash <= 1'b0;
                    if (tick) begin
                        cnt <= CNT_RELOAD;
                        if (gapcnt == '0) begin
                            if (!empty) begin
                                cur   <= mem[rd_ptr];
                                state <= LOAD;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            gapcnt <= gapcnt - 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Bench for morse_msg_sequencer: a per-cycle schedule model of the Morse stream
// plus directed scenarios pinned with hand-computed literals.
module tb_morse_msg_sequencer;

    localparam int DIV        = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_UNITS  = 3;

    logic       ClockIn = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] LetterIn = '0;
    logic       LetterValid = 1'b0;
    logic       LetterReady;
    logic       Abort = 1'b0;
    logic       DotDashOut, NewBitOut, Busy, Done;

    morse_msg_sequencer #(.DIV(DIV), .FIFO_DEPTH(FIFO_DEPTH), .GAP_UNITS(GAP_UNITS)) dut (
        .ClockIn(ClockIn), .Reset(Reset), .LetterIn(LetterIn), .LetterValid(LetterValid),
        .LetterReady(LetterReady), .Abort(Abort), .DotDashOut(DotDashOut),
        .NewBitOut(NewBitOut), .Busy(Busy), .Done(Done)
    );

    always #5 ClockIn = ~ClockIn;

    localparam logic [2:0] L_A = 3'd0, L_B = 3'd1, L_C = 3'd2, L_D = 3'd3,
                           L_E = 3'd4, L_F = 3'd5, L_G = 3'd6, L_H = 3'd7;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] pat(input logic [2:0] c);
        case (c)
            3'd0:    return 11'b10111000000;
            3'd1:    return 11'b11101010100;
            3'd2:    return 11'b11101011101;
            3'd3:    return 11'b11101010000;
            3'd4:    return 11'b10000000000;
            3'd5:    return 11'b10101110100;
            3'd6:    return 11'b11101110100;
            default: return 11'b10101010000;
        endcase
    endfunction

    // Model: a queue of waiting letters and a cycle-by-cycle schedule of the
    // expected output levels for the letter currently being played.
    typedef struct packed {
        logic dd;
        logic nb;
        logic last;
    } slot_t;

    slot_t      sched[$];
    logic [2:0] lq[$];
    logic       levels[$];
    int         done_cnt = 0;
    bit         model_reset = 0;

    task automatic gen(input logic [2:0] code);
        logic [10:0] p;
        int len;
        slot_t s;
        p = pat(code);
        len = 0;
        for (int i = 0; i < 11; i++) if (p[10-i]) len = i + 1;
        s = '0;
        sched.push_back(s);
        for (int u = 0; u < len + GAP_UNITS; u++) begin
            for (int c = 0; c < DIV; c++) begin
                s.dd   = (u < len) ? p[10-u] : 1'b0;
                s.nb   = (c == DIV - 1);
                s.last = (u == len + GAP_UNITS - 1) && (c == DIV - 1);
                sched.push_back(s);
            end
        end
    endtask

    always @(negedge ClockIn) begin
        slot_t cs;
        logic  e_ready, e_busy, e_done, e_nb;
        if (model_reset) begin
            sched.delete();
            lq.delete();
            model_reset = 0;
        end
        if (!Reset) begin
            cs      = (sched.size() != 0) ? sched[0] : '0;
            e_ready = (lq.size() < FIFO_DEPTH) && !Abort;
            e_busy  = (sched.size() != 0) || (lq.size() != 0);
            e_done  = cs.last && (lq.size() == 0) && !Abort;
            e_nb    = cs.nb && !Abort;
            check("cycle{dd,nb,busy,done,ready}",
                  32'({DotDashOut, NewBitOut, Busy, Done, LetterReady}),
                  32'({cs.dd, e_nb, e_busy, e_done, e_ready}));
            if (NewBitOut) levels.push_back(DotDashOut);
            if (Done) done_cnt++;
            if (Abort) begin
                sched.delete();
                lq.delete();
            end else begin
                if (sched.size() != 0) void'(sched.pop_front());
                if (sched.size() == 0 && lq.size() != 0) gen(lq.pop_front());
                if (LetterValid && e_ready) lq.push_back(LetterIn);
            end
        end
    end

    int stalls;

    task automatic push_one(input logic [2:0] code);
        bit acc;
        int n;
        LetterIn    = code;
        LetterValid = 1'b1;
        acc = 0;
        n = 0;
        stalls = 0;
        while (!acc && n < 2000) begin
            @(negedge ClockIn);
            acc = LetterReady;
            if (!acc) stalls++;
            @(posedge ClockIn);
            #1;
            n++;
        end
        LetterValid = 1'b0;
        check("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge ClockIn);
        while (Busy && n < 4000) begin
            @(negedge ClockIn);
            n++;
        end
        check("idle_within_budget", 32'(Busy), 32'd0);
        @(posedge ClockIn);
        #1;
    endtask

    task automatic wait_nb(input int k);
        int seen, n;
        seen = 0;
        n = 0;
        while (seen < k && n < 2000) begin
            @(negedge ClockIn);
            if (NewBitOut) seen++;
            n++;
        end
        check("newbit_within_budget", 32'(seen), 32'(k));
        @(posedge ClockIn);
        #1;
    endtask

    task automatic check_levels(input string name, input int n, input logic [31:0] exp);
        logic [31:0] got;
        got = '0;
        check({name, "_count"}, 32'(levels.size()), 32'(n));
        foreach (levels[i]) got = {got[30:0], levels[i]};
        check(name, got, exp);
    endtask

    initial begin
        int d0, t0, t1, nbs, n;
        repeat (2) @(posedge ClockIn);
        #1 Reset = 1'b0;

        // Reset state
        @(negedge ClockIn);
        check("reset_outputs{dd,nb,busy,done}", 32'({DotDashOut, NewBitOut, Busy, Done}), 32'd0);
        check("reset_ready", 32'(LetterReady), 32'd1);
        @(posedge ClockIn);
        #1;

        // Single E, cycle 0 = push cycle
        levels.delete();
        d0 = done_cnt;
        push_one(L_E);
        for (int c = 1; c <= 19; c++) begin
            @(negedge ClockIn);
            check($sformatf("E_dd_c%0d", c), 32'(DotDashOut), 32'(c >= 3 && c <= 6));
            check($sformatf("E_nb_c%0d", c), 32'(NewBitOut),
                  32'(c == 6 || c == 10 || c == 14 || c == 18));
            check($sformatf("E_done_c%0d", c), 32'(Done), 32'(c == 18));
            check($sformatf("E_busy_c%0d", c), 32'(Busy), 32'(c <= 18));
            @(posedge ClockIn);
            #1;
        end
        check("E_done_count", 32'(done_cnt - d0), 32'd1);

        // Queue "AB"
        levels.delete();
        d0 = done_cnt;
        push_one(L_A);
        push_one(L_B);
        wait_idle();
        check_levels("AB_levels", 20, 32'h000B8EA8);
        check("AB_done_count", 32'(done_cnt - d0), 32'd1);

        // Backpressure: six letters back-to-back
        levels.delete();
        d0 = done_cnt;
        push_one(L_D);
        push_one(L_G);
        push_one(L_F);
        push_one(L_A);
        push_one(L_E);
        check("bp_no_stall_fifth", 32'(stalls), 32'd0);
        push_one(L_H);
        check("bp_sixth_stalled", 32'(stalls > 0), 32'd1);
        wait_idle();
        check("bp_unit_count", 32'(levels.size()), 32'd56);
        check("bp_done_count", 32'(done_cnt - d0), 32'd1);

        // Abort during C's third unit
        d0 = done_cnt;
        push_one(L_C);
        wait_nb(2);
        @(posedge ClockIn);
        #1 Abort = 1'b1;
        @(posedge ClockIn);
        #1 Abort = 1'b0;
        @(negedge ClockIn);
        check("abort_after{dd,busy,ready}", 32'({DotDashOut, Busy, LetterReady}), 32'b001);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        @(posedge ClockIn);
        #1;
        levels.delete();
        push_one(L_E);
        wait_idle();
        check_levels("abort_then_E", 4, 32'h8);
        check("abort_then_E_done", 32'(done_cnt - d0), 32'd1);

        // Async reset mid-gap
        d0 = done_cnt;
        push_one(L_E);
        wait_nb(2);
        #1 Reset = 1'b1;
        model_reset = 1;
        #1;
        check("areset_outputs{dd,nb,busy,done}", 32'({DotDashOut, NewBitOut, Busy, Done}), 32'd0);
        check("areset_ready", 32'(LetterReady), 32'd1);
        #1 Reset = 1'b0;
        levels.delete();
        push_one(L_H);
        wait_idle();
        check_levels("reset_then_H", 10, 32'h2A8);
        check("reset_then_H_done", 32'(done_cnt - d0), 32'd1);

        // C: all 11 units, gap only after the last
        levels.delete();
        push_one(L_C);
        t0 = -1;
        t1 = -1;
        nbs = 0;
        n = 0;
        while (t1 < 0 && n < 2000) begin
            @(negedge ClockIn);
            if (DotDashOut && t0 < 0) t0 = n;
            if (t0 >= 0 && NewBitOut) nbs++;
            if (Done) t1 = n;
            n++;
        end
        check("C_send_gap_cycles", 32'(t1 - t0 + 1), 32'(14 * DIV));
        check("C_unit_ticks", 32'(nbs), 32'd14);
        @(posedge ClockIn);
        #1;
        wait_idle();
        check_levels("C_levels", 14, 32'h3AE8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/morse_msg_sequencer.md
# morse_msg_sequencer

Sequences a queue of 3-bit letter codes (A–H) into a continuous Morse bit stream for the lab 5 LED/buzzer path. It buffers letters in a small FIFO and sends each one's dot/dash pattern with trailing zeros trimmed, one unit per divided-clock tick. It inserts a fixed inter-letter gap and signals when the message drains. It replaces the manual Start-per-letter flow: the board top level drives letters in, and this block owns the rate divider, pattern lookup, shifting and gap timing.

## Interface
- DIV, 250: clock cycles per Morse unit; legal range ≥2.
- FIFO_DEPTH, 4: letter queue entries; power of 2, ≥2.
- GAP_UNITS, 3: zero units appended after each letter; ≥1.
- ClockIn  input  1  single clock, all state on posedge.
- Reset  input  1  asynchronous, active-high; clears all state.
- LetterIn  input  3  letter code: 000=A … 111=H.
- LetterValid  input  1  requester offers LetterIn this cycle.
- LetterReady  output  1  queue can accept; defined as !full && !Abort.
- Abort  input  1  synchronous flush of the queue and current letter.
- DotDashOut  output  1  Morse level; 1 = on.
- NewBitOut  output  1  one-cycle pulse on every unit boundary while not IDLE.
- Busy  output  1  state != IDLE or queue non-empty.
- Done  output  1  one-cycle pulse when the last queued letter's gap completes.

## Operation
- Patterns are 11 bits, MSB first:
  - A=10111000000, B=11101010100, C=11101011101, D=11101010000
  - E=10000000000, F=10101110100, G=11101110100, H=10101010000
- FIFO behaviour:
  - Push on LetterValid && LetterReady.
  - Pop only on a transition into LOAD; the popped code goes to the cur register.
  - Push and pop in the same cycle are both honoured.
  - When full, LetterReady=0 and offers are held off, never dropped.
- States are IDLE, LOAD, SEND and GAP.
  - **IDLE**
    - Outputs DotDashOut=0, NewBitOut=0.
    - If the queue is non-empty: pop and go to LOAD.
  - **LOAD** (1 cycle)
    - shreg ← pattern(cur); tick counter ← DIV-1.
    - Go to SEND.
  - **SEND**
    - DotDashOut = shreg[10].
    - Tick counter decrements each cycle. At 0: NewBitOut=1, counter ← DIV-1, shreg ← shreg<<1.
    - If the shifted value is 0: gapcnt ← GAP_UNITS-1 and go to GAP.
  - **GAP**
    - DotDashOut=0.
    - On each tick (counter==0): NewBitOut=1, counter reloads.
    - If gapcnt==0: when the queue is non-empty, pop and go to LOAD; otherwise Done=1 and go to IDLE.
    - Otherwise gapcnt decrements.
- Letter length = index of the last 1 in the pattern + 1 (A=5, B=9, C=11, E=1 units).
- Abort takes priority over everything except Reset.
  - Next cycle: state=IDLE, queue empty, DotDashOut=0.
  - No Done pulse; any push in the Abort cycle is ignored.
- Widths:
  - Tick counter: ceil(log2(DIV)) bits.
  - gapcnt: ceil(log2(GAP_UNITS+1)) bits.
  - FIFO: log2(FIFO_DEPTH) pointers plus a separate occupancy count of log2(FIFO_DEPTH)+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: state=IDLE, queue empty, DotDashOut=0, NewBitOut=0, Busy=0, Done=0. LetterReady=1 (combinational from the empty queue).
- Push into an empty, idle block:
  - Cycle N: push.
  - N+1: IDLE pops; Busy=1 from this cycle.
  - N+2: LOAD.
  - N+3: first SEND cycle, DotDashOut=1.
- Every unit, including the first, lasts exactly DIV cycles. NewBitOut fires on the last cycle of each unit.
- Letter plus gap occupies (len+GAP_UNITS)·DIV cycles of SEND/GAP.
- Back-to-back letters add exactly 1 LOAD cycle (DotDashOut=0) between the gap end and the next letter.
- Done is asserted in the final GAP cycle; Busy falls the following cycle.
- Reset mid-letter takes effect immediately, asynchronously, with the same values as power-up.

## Test plan
- **Single E**, DIV=4, GAP_UNITS=3:
  - Push E at cycle 0.
  - DotDashOut=1 for cycles 3–6, then 0 for cycles 7–18.
  - Done pulses at cycle 18; NewBitOut pulses at cycles 6, 10, 14, 18.
- **Queue "AB"**, DIV=4:
  - A drives 1,0,1,1,1 over units of 4 cycles each, then a 12-cycle gap.
  - One LOAD cycle follows, then B drives 1,1,1,0,1,0,1,0,1.
  - Exactly one Done pulse, after B's gap.
- **Backpressure**, FIFO_DEPTH=4:
  - Push 6 letters back-to-back while the first is still sending.
  - LetterReady drops once 4 letters are queued behind the active letter.
  - All 6 letters emerge in order; none is lost or duplicated.
- **Abort during C's third unit**:
  - Next cycle: DotDashOut=0, Busy=0, queue empty.
  - No Done pulse; a letter pushed afterwards sends normally.
- **Async Reset pulse mid-gap**, between clock edges:
  - Outputs clear before the next edge.
  - A fresh push of H yields 1,0,1,0,1,0,1.
- **C (full 11 units, last bit 1)**:
  - GAP is entered only after the 11th unit.
  - Total SEND+GAP time = 14·DIV cycles.
